clk_div_switch: RTL and testbench



---
 rtl/clk_div_switch_pkg.sv | 24 ++
 rtl/clk_gate_latch.sv | 27 ++
 rtl/clk_div_switch.sv | 165 ++++++++++++++++
 tb/tb_clk_div_switch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_switch_pkg.sv
// Shared types and constants for the clk_div_switch clock divider/switch.
//   state_t    : controller states (STOP, RUN, DRAIN, GAP)
//   ratio_t    : ratio field at the default width
//   RATIO_STOP : ratio value meaning "clock held stopped"
package clk_div_switch_pkg;

  localparam int unsigned DEF_DIV_W  = 8;
  localparam int unsigned RATIO_STOP = 0;

  typedef logic [DEF_DIV_W-1:0] ratio_t;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // States in which the current ratio is producing clock periods.
  function automatic logic is_clocking(state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/clk_gate_latch.sv
// Glitch-free clock gate for the divide-by-1 path.
//   clk  : source clock
//   rst  : asynchronous active-high clear of the enable latch
//   en   : gate enable, launched from posedge clk
//   gclk : clk AND latched enable
// The enable latch is transparent while clk is low, so the gated clock only
// ever produces whole high pulses of clk.
module clk_gate_latch (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic gclk
);

  logic en_q;

  always_latch begin
    if (rst) begin
      en_q <= 1'b0;
    end else if (!clk) begin
      en_q <= en;
    end
  end

  assign gclk = clk & en_q;

endmodule

// File: rtl/clk_div_switch.sv
// Runtime-programmable glitch-free clock divider/switch.
//   clk         : source clock
//   rst         : asynchronous active-high reset
//   req_valid   : ratio change request
//   req_ratio   : requested ratio (0 = stop)
//   req_ready   : request can be accepted (STOP and RUN only)
//   clk_out     : divided / gated clock
//   cur_ratio   : ratio currently driving clk_out
//   period_tick : pulse on the last source cycle of each clk_out period
// Optional feature: define CLK_DIV_SWITCH_GAP_EN to insert GAP_CYC low
// dead-time cycles before every new clock starts.
module clk_div_switch
  import clk_div_switch_pkg::*;
#(
  parameter int unsigned DIV_W   = DEF_DIV_W,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [DIV_W-1:0] req_ratio,
  output logic             req_ready,
  output logic             clk_out,
  output logic [DIV_W-1:0] cur_ratio,
  output logic             period_tick
);

  typedef logic [DIV_W-1:0] rat_t;

  localparam rat_t R_STOP = rat_t'(RATIO_STOP);
  localparam rat_t R_ONE  = rat_t'(1);
  localparam rat_t R_TWO  = rat_t'(2);

`ifdef CLK_DIV_SWITCH_GAP_EN
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
`else
  // GAP_CYC has no effect without the gap feature.
  logic unused_gap_cfg;
  assign unused_gap_cfg = ^GAP_CYC;
`endif

  typedef struct packed {
    state_t state;
    rat_t   cnt;
    rat_t   cur;
    rat_t   pend;
`ifdef CLK_DIV_SWITCH_GAP_EN
    logic [GW-1:0] gap;
`endif
  } ctx_t;

  ctx_t ctx;
  ctx_t nxt;
  logic clk_reg;
  logic gate_en;
  logic clk_gated;

  // One source cycle of autonomous progress (no new request).
  // DRAIN with cur==0 is the one-cycle start-up stage entered from STOP.
  function automatic ctx_t advance(ctx_t c);
    ctx_t n;
    logic wrap;
    n    = c;
    wrap = (c.cur == R_STOP) || (c.cnt == c.cur - R_ONE);
    case (c.state)
      ST_RUN: begin
        n.cnt = wrap ? '0 : c.cnt + R_ONE;
      end
      ST_DRAIN: begin
        if (wrap) begin
          n.cnt = '0;
          if (c.pend == R_STOP) begin
            n.state = ST_STOP;
            n.cur   = R_STOP;
          end
`ifdef CLK_DIV_SWITCH_GAP_EN
          else if (GAP_CYC != 0) begin
            n.state = ST_GAP;
            n.gap   = '0;
          end
`endif
          else begin
            n.state = ST_RUN;
            n.cur   = c.pend;
          end
        end else begin
          n.cnt = c.cnt + R_ONE;
        end
      end
`ifdef CLK_DIV_SWITCH_GAP_EN
      ST_GAP: begin
        if (c.gap == GW'(GAP_CYC - 1)) begin
          n.state = ST_RUN;
          n.cur   = c.pend;
          n.cnt   = '0;
        end else begin
          n.gap = c.gap + 1'b1;
        end
      end
`endif
      default: ;
    endcase
    return n;
  endfunction

  // The gate latch adds one cycle of delay, so its enable is launched one
  // cycle early: true when the cycle after the *next* edge runs at ratio 1.
  // Requests at that next edge cannot change this (RUN->DRAIN keeps the ratio).
  function automatic logic ratio1_ahead(ctx_t c);
    ctx_t n;
    n = advance(c);
    return is_clocking(n.state) && (n.cur == R_ONE);
  endfunction

  assign req_ready = (ctx.state == ST_STOP) || (ctx.state == ST_RUN);

  always_comb begin
    nxt = advance(ctx);
    if (req_valid && req_ready) begin
      if (ctx.state == ST_STOP) begin
        if (req_ratio != R_STOP) begin
          nxt.state = ST_DRAIN;
          nxt.cnt   = '0;
          nxt.cur   = R_STOP;
          nxt.pend  = req_ratio;
        end
      end else if (req_ratio != ctx.cur) begin
        nxt.state = ST_DRAIN;
        nxt.pend  = req_ratio;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx.state <= ST_STOP;
      ctx.cnt   <= '0;
      ctx.cur   <= '0;
      ctx.pend  <= '0;
`ifdef CLK_DIV_SWITCH_GAP_EN
      ctx.gap   <= '0;
`endif
      clk_reg   <= 1'b0;
      gate_en   <= 1'b0;
    end else begin
      ctx     <= nxt;
      clk_reg <= is_clocking(nxt.state) && (nxt.cur >= R_TWO) &&
                 (nxt.cnt < (nxt.cur >> 1));
      gate_en <= ratio1_ahead(nxt);
    end
  end

  clk_gate_latch u_gate (
    .clk  (clk),
    .rst  (rst),
    .en   (gate_en),
    .gclk (clk_gated)
  );

  assign clk_out     = clk_reg | clk_gated;
  assign cur_ratio   = ctx.cur;
  assign period_tick = is_clocking(ctx.state) && (ctx.cur != R_STOP) &&
                       (ctx.cnt == ctx.cur - R_ONE);

endmodule

// File: tb/tb_clk_div_switch.sv
module tb_clk_div_switch;

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned GAP_CYC = 2;
`ifdef CLK_DIV_SWITCH_GAP_EN
  localparam int unsigned G = GAP_CYC;
`else
  localparam int unsigned G = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [DIV_W-1:0] req_ratio;
  logic             req_ready;
  logic             clk_out;
  logic [DIV_W-1:0] cur_ratio;
  logic             period_tick;

  always #5 clk = ~clk;

  clk_div_switch #(
    .DIV_W   (DIV_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ratio   (req_ratio),
    .req_ready   (req_ready),
    .clk_out     (clk_out),
    .cur_ratio   (cur_ratio),
    .period_tick (period_tick)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: the clock is a train of periods of length m_ratio that
  // began at edge m_start; a pending switch takes effect at edge m_sw, with
  // the old train ending at edge m_gap_from.
  int unsigned k          = 0;
  int unsigned m_ratio    = 0;
  int unsigned m_start    = 0;
  int unsigned m_new      = 0;
  int unsigned m_sw       = 0;
  int unsigned m_gap_from = 0;
  bit          m_pend     = 1'b0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic bit model_run();
    return (m_ratio != 0) && !(m_pend && (k >= m_gap_from));
  endfunction

  function automatic int unsigned model_pos();
    return model_run() ? (k - m_start) % m_ratio : 0;
  endfunction

  task automatic model_reset();
    m_ratio = 0;
    m_pend  = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned c;
    k++;
    if (m_pend) begin
      if (k == m_sw) begin
        m_ratio = m_new;
        m_start = k;
        m_pend  = 1'b0;
      end
    end else if (req_valid) begin
      if (m_ratio == 0) begin
        if (req_ratio != 0) begin
          m_pend     = 1'b1;
          m_new      = req_ratio;
          m_gap_from = k + 1;
          m_sw       = k + 1 + G;
        end
      end else if (req_ratio != m_ratio) begin
        c          = (k - m_start) % m_ratio;
        m_pend     = 1'b1;
        m_new      = req_ratio;
        m_gap_from = k + (m_ratio - c);
        m_sw       = m_gap_from + ((req_ratio != 0) ? G : 0);
      end
    end
  endtask

  task automatic check_all(input bit hi);
    bit          run;
    int unsigned pos;
    bit          e_clk;
    bit          e_tick;
    run    = model_run();
    pos    = model_pos();
    e_clk  = run && ((m_ratio == 1) ? hi : (pos < m_ratio / 2));
    e_tick = run && (pos == m_ratio - 1);
    if (hi) begin
      check_eq("clk_out_hi", clk_out, e_clk);
      check_eq("tick", period_tick, e_tick);
      check_eq("cur_ratio", cur_ratio, m_ratio);
      check_eq("req_ready", req_ready, !m_pend);
    end else begin
      check_eq("clk_out_lo", clk_out, e_clk);
      check_eq("tick_lo", period_tick, e_tick);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1 check_all(1'b1);
    @(negedge clk);
    #1 check_all(1'b0);
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (!req_ready && n < 600) begin
      step();
      n++;
    end
    check_eq("ready_wait", req_ready, 1);
  endtask

  task automatic issue(input int unsigned ratio);
    wait_ready();
    req_valid = 1'b1;
    req_ratio = DIV_W'(ratio);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_pos(input int unsigned ratio, input int unsigned p);
    int unsigned n = 0;
    while (!(model_run() && !m_pend && m_ratio == ratio && model_pos() == p) && n < 100) begin
      step();
      n++;
    end
    check_eq("pos_wait", (n < 100) ? 1 : 0, 1);
  endtask

  initial begin
    int unsigned lows;
    req_valid = 1'b0;
    req_ratio = '0;
    rst       = 1'b0;
    #1 rst    = 1'b1;
    #2;
    check_eq("reset_clk_out", clk_out, 0);
    check_eq("reset_ready", req_ready, 1);
    check_eq("reset_cur", cur_ratio, 0);
    check_eq("reset_tick", period_tick, 0);
    steps(3);
    rst = 1'b0;
    steps(2);

    // Start from STOP at ratio 4; a stop request while stopped is a no-op.
    issue(0);
    steps(2);
    issue(4);
    steps(12);

    // Ratio 5, switch to 2 requested one cycle into a period.
    issue(5);
    wait_pos(5, 0);
    req_valid = 1'b1;
    req_ratio = DIV_W'(2);
    step();
    req_valid = 1'b0;
    lows = 0;
    while (!req_ready && lows < 20) begin
      lows++;
      step();
    end
    check_eq("drain_ready_low", lows, 4 + G);
    steps(6);

    // Same-ratio request is a no-op, then 2 -> 1 -> 3.
    issue(2);
    steps(4);
    issue(1);
    steps(6);
    issue(3);
    steps(9);

    // Stop while running at 6.
    issue(6);
    steps(8);
    issue(0);
    steps(12);

    // 4 -> 3 (gap cycles appear when the gap feature is built in).
    issue(4);
    steps(8);
    issue(3);
    steps(12);

    // Reset during a high phase at ratio 8 with a switch pending.
    issue(8);
    wait_pos(8, 7);
    req_valid = 1'b1;
    req_ratio = DIV_W'(3);
    step();
    req_valid = 1'b0;
    step();
    check_eq("pre_rst_clk_out", clk_out, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_clk_out", clk_out, 0);
    check_eq("rst_async_ready", req_ready, 1);
    check_eq("rst_async_cur", cur_ratio, 0);
    steps(2);
    rst = 1'b0;
    steps(10);

    // Randomized traffic; requests arrive regardless of req_ready.
    for (int unsigned i = 0; i < 2500; i++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) req_ratio = DIV_W'($urandom_range(10, 255));
      else req_ratio = DIV_W'($urandom_range(0, 8));
      step();
    end
    req_valid = 1'b0;
    steps(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
